div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL provide parameter EARLY_ZERO, default 1, meaning: 1 = a zero divisor completes via the 1-cycle ZERO path; 0 = it runs the full iteration sequence with a raw, undefined result.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock only.
REQ-003 resetn  input  1  reset; asynchronous, active-low.
REQ-004 start_i  input  1  divide request from the execute stage, held high while stall_o=1.
REQ-005 signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 opa_i  input  32  dividend (rs).
REQ-007 opb_i  input  32  divisor (rt).
REQ-008 flush_i  input  1  exception/ERET annul of the in-flight divide.
REQ-009 stall_o  output  1  pipeline hold request.
REQ-010 valid_o  output  1  1-cycle pulse; hi_o/lo_o are to be written to HI/LO.
REQ-011 hi_o  output  32  remainder.
REQ-012 lo_o  output  32  quotient.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ZERO, RUN, DONE.
REQ-014 IDLE, start_i=1, flush_i=0, opb_i=0, EARLY_ZERO=1: the next state SHALL be ZERO; opa_i SHALL be latched.
REQ-015 IDLE, start_i=1, flush_i=0, otherwise: the block SHALL latch the magnitudes of opa_i/opb_i (two's-complement absolute value only when signed_i=1), the dividend sign, and the quotient sign (XOR of operand signs when signed); it SHALL clear the 5-bit iteration counter and go to RUN.
REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle on a 33-bit partial remainder, yielding one quotient bit per cycle, MSB first.
REQ-017 RUN SHALL last exactly 32 cycles: counter 0..31, then DONE after the counter=31 step; the counter SHALL NOT wrap into a further iteration.
REQ-018 ZERO SHALL last 1 cycle, then DONE, with quotient 0xFFFFFFFF and remainder = latched opa_i.
REQ-019 In DONE the block SHALL pulse valid_o=1 for exactly one cycle and register hi_o/lo_o; next state IDLE.
REQ-020 Sign correction in DONE: quotient SHALL be negated when the quotient sign is set; remainder SHALL be negated when the dividend sign is set; both SHALL be applied only when signed_i was 1 at accept.
REQ-021 Overflow case 0x80000000 / 0xFFFFFFFF (signed) SHALL yield lo=0x80000000, hi=0, with no trap.
REQ-022 stall_o SHALL be combinationally 1 in:
- the IDLE accept cycle (start_i=1, flush_i=0);
- every RUN and ZERO cycle.
REQ-023 stall_o SHALL be 0 in DONE, so the issuing instruction advances in the same cycle valid_o=1.
REQ-024 start_i seen in DONE SHALL be ignored (same instruction); only start_i seen in IDLE begins a new divide.
REQ-025 Latency, with accept cycle = cycle 0:
- normal divide: valid_o at cycle 33, stall_o high cycles 0..32;
- zero-divisor path: valid_o at cycle 2.
REQ-026 flush_i=1 in any state SHALL:
- force the next state to IDLE;
- suppress valid_o and stall_o in that cycle;
- leave hi_o/lo_o unchanged.
REQ-027 flush_i SHALL take priority over start_i in the same cycle.
REQ-028 hi_o/lo_o SHALL hold the last completed result until the next DONE.
REQ-029 Operands SHALL be sampled only at accept; changes on opa_i/opb_i/signed_i during RUN SHALL NOT affect the result.

Reset
REQ-030 resetn=0 SHALL asynchronously, in any state including mid-RUN:
- force IDLE;
- clear the counter, partial remainder and sign flags;
- drive stall_o=0, valid_o=0, hi_o=0, lo_o=0.
REQ-031 After resetn rises, the first start_i sampled in IDLE SHALL be accepted normally.

Verification
REQ-032 Unsigned divide: DIVU, opa=100, opb=7 -> valid_o at cycle 33, lo=14, hi=2; stall_o high cycles 0..32.
REQ-033 Signed divide: DIV, opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 Signed overflow: DIV, opa=0x80000000, opb=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 Zero divisor: EARLY_ZERO=1, opa=5, opb=0 -> valid_o at cycle 2, lo=0xFFFFFFFF, hi=5.
REQ-036 Flush mid-divide: flush_i at cycle 10 of a DIVU -> no valid_o, stall_o low from cycle 10, hi/lo unchanged; then a new DIVU 9/3 accepted in IDLE -> lo=3, hi=0.
REQ-037 Reset mid-divide: resetn low at cycle 20 of RUN -> all outputs 0 immediately; the held start_i is re-accepted after release.

Source files
------------

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl -- iterative 32-bit DIV/DIVU unit for the execute stage.
//
// A request is accepted in IDLE, then either takes the one-cycle ZERO path
// (zero divisor with EARLY_ZERO=1) or runs 32 restoring shift-subtract steps
// in RUN. DONE applies the sign correction, pulses valid_o and captures the
// result into the HI/LO holding registers.
//
// Ports
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset
//   start_i   divide request, held high while stall_o=1
//   signed_i  1 = DIV (two's complement), 0 = DIVU
//   opa_i     dividend (rs)
//   opb_i     divisor (rt)
//   flush_i   annuls the in-flight divide
//   stall_o   pipeline hold request
//   valid_o   one-cycle pulse, hi_o/lo_o are to be written to HI/LO
//   hi_o      remainder
//   lo_o      quotient
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int EARLY_ZERO = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  count;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        accept;
  logic        zero_take;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] lo_res;
  logic [31:0] hi_res;

  // Accept decode and operand magnitudes for the IDLE cycle.
  always_comb begin
    accept    = (state == IDLE) && start_i && !flush_i;
    zero_take = (EARLY_ZERO != 0) && (opb_i == 32'd0);
    a_neg     = signed_i && opa_i[31];
    b_neg     = signed_i && opb_i[31];
    a_mag     = a_neg ? (32'd0 - opa_i) : opa_i;
    b_mag     = b_neg ? (32'd0 - opb_i) : opb_i;
  end

  // One restoring step: the 33-bit partial remainder is the held remainder
  // shifted left with the next dividend bit; a clear borrow (diff[32]==0)
  // means the divisor fits and the quotient bit is 1. The held remainder is
  // always below the divisor, so it fits in 32 bits.
  always_comb begin
    shifted = {rem, quot[31]};
    diff    = shifted - {1'b0, divisor};
    qbit    = ~diff[32];
  end

  // Sign correction; both flags are already zero for unsigned and ZERO-path
  // requests, so the raw values pass through untouched.
  always_comb begin
    lo_res = neg_q ? (32'd0 - quot) : quot;
    hi_res = neg_r ? (32'd0 - rem) : rem;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything, including a new start.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) state_next = zero_take ? ZERO : RUN;
        ZERO: state_next = DONE;
        RUN:  if (count == 5'd31) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: operand capture at accept, iteration in RUN, and the HI/LO
  // holding registers updated only on an unflushed DONE. The quotient
  // register starts out holding the dividend and shifts quotient bits in
  // from the bottom as dividend bits leave the top.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= 5'd0;
      rem     <= 32'd0;
      quot    <= 32'd0;
      divisor <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (accept) begin
      count <= 5'd0;
      if (zero_take) begin
        rem     <= opa_i;
        quot    <= 32'hFFFF_FFFF;
        divisor <= 32'd0;
        neg_q   <= 1'b0;
        neg_r   <= 1'b0;
      end else begin
        rem     <= 32'd0;
        quot    <= a_mag;
        divisor <= b_mag;
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
      end
    end else if ((state == RUN) && !flush_i) begin
      rem  <= qbit ? diff[31:0] : shifted[31:0];
      quot <= {quot[30:0], qbit};
      if (count != 5'd31) begin
        count <= count + 5'd1;
      end
    end else if ((state == DONE) && !flush_i) begin
      hi_q <= hi_res;
      lo_q <= lo_res;
    end
  end

  // Outputs. In DONE the corrected result is shown directly so HI/LO can be
  // written in the same cycle as valid_o; otherwise the held result shows.
  // stall_o is gated by resetn so a held start_i cannot stall during reset.
  always_comb begin
    stall_o = 1'b0;
    valid_o = 1'b0;
    hi_o    = hi_q;
    lo_o    = lo_q;
    if (resetn && !flush_i) begin
      case (state)
        IDLE: stall_o = start_i;
        ZERO: stall_o = 1'b1;
        RUN:  stall_o = 1'b1;
        DONE: begin
          valid_o = 1'b1;
          hi_o    = hi_res;
          lo_o    = lo_res;
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

endmodule
